// File: rtl/accum_drain_pkg.sv
// accum_drain_pkg: state encoding, default beat width and beat-select helper.
package accum_drain_pkg;
   localparam int DEFAULT_WIDTH = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, SEND_A = 2'd1, SEND_B = 2'd2} state_t;
   // 1 selects the upper half of the snapshot for the beat being sent
   function automatic logic half_sel(input logic second, input logic hi_first);
      return second ^ hi_first;
   endfunction
endpackage

// File: rtl/accum_drain_if.sv
// accum_drain_if: valid/ready beat stream carrying drained accumulator halves.
interface accum_drain_if #(parameter int DATA_WIDTH = 32);
   logic [DATA_WIDTH-1:0] m_data;
   logic m_valid;
   logic m_ready;
   logic m_last;
   modport master(output m_data, output m_valid, output m_last, input m_ready);
   modport slave(input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/accum_drain.sv
// accum_drain: snapshots the accumulator on Capture, clears it, and streams the
// result as two beats; one pending slot absorbs a capture taken while draining.
import accum_drain_pkg::*;
module accum_drain #(
   parameter int DATA_WIDTH = DEFAULT_WIDTH,
   parameter bit HI_FIRST = 1'b0
) (
   input  logic Clk,
   input  logic Rst,
   input  logic [2*DATA_WIDTH-1:0] sum,
   input  logic Capture,
   output logic Clr_acc,
   accum_drain_if.master m,
   output logic Busy,
   output logic Overflow
);
   state_t state, state_nx;
   logic [2*DATA_WIDTH-1:0] active, pending;
   logic pend_v, xfer, send_b_xfer, accept, to_active, to_pend;
   assign xfer = m.m_valid && m.m_ready;
   assign send_b_xfer = state == SEND_B && xfer;
   // the final-beat edge frees a slot, so a capture there is always taken
   assign accept = Capture && (state == IDLE || send_b_xfer || !pend_v);
   assign to_active = Capture && (state == IDLE || (send_b_xfer && !pend_v));
   assign to_pend = accept && !to_active;
   always_ff @(posedge Clk) begin
      if (Rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = Capture ? SEND_A : IDLE;
         SEND_A:  state_nx = xfer ? SEND_B : SEND_A;
         SEND_B:  state_nx = !xfer ? SEND_B : (pend_v || Capture) ? SEND_A : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      m.m_valid = state != IDLE;
      m.m_last = state == SEND_B;
      m.m_data = state == IDLE ? '0 :
                 half_sel(state == SEND_B, HI_FIRST) ? active[2*DATA_WIDTH-1:DATA_WIDTH] :
                 active[DATA_WIDTH-1:0];
      Busy = state != IDLE || pend_v;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         active <= '0;
         pending <= '0;
         pend_v <= 1'b0;
         Clr_acc <= 1'b0;
         Overflow <= 1'b0;
      end else begin
         Clr_acc <= accept;
         Overflow <= Overflow || (Capture && !accept);
         if (to_active) active <= sum;
         else if (send_b_xfer && pend_v) active <= pending;
         if (to_pend) pending <= sum;
         pend_v <= to_pend || (pend_v && !send_b_xfer);
      end
   end
endmodule

// File: tb/tb_accum_drain.sv
// tb_accum_drain: drives HI_FIRST=0 and HI_FIRST=1 instances with the same stimulus
// and checks both against a two-entry result-queue model every cycle.
module tb_accum_drain;
   localparam int W = 32;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   logic [2*W-1:0] sum = '0;
   logic Capture = 1'b0;
   logic ready = 1'b0;
   logic clr0, busy0, ovf0, clr1, busy1, ovf1;
   int compared = 0;
   int mismatched = 0;
   logic [2*W-1:0] q[$];
   int bi = 0;
   logic movf = 1'b0;
   logic mclr = 1'b0;
   accum_drain_if #(.DATA_WIDTH(W)) b0();
   accum_drain_if #(.DATA_WIDTH(W)) b1();
   assign b0.m_ready = ready;
   assign b1.m_ready = ready;
   accum_drain #(.DATA_WIDTH(W), .HI_FIRST(1'b0)) dut0 (
      .Clk(Clk), .Rst(Rst), .sum(sum), .Capture(Capture), .Clr_acc(clr0),
      .m(b0.master), .Busy(busy0), .Overflow(ovf0));
   accum_drain #(.DATA_WIDTH(W), .HI_FIRST(1'b1)) dut1 (
      .Clk(Clk), .Rst(Rst), .sum(sum), .Capture(Capture), .Clr_acc(clr1),
      .m(b1.master), .Busy(busy1), .Overflow(ovf1));
   always #5 Clk = ~Clk;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   // one clock: update the model with the inputs seen at the edge, then compare
   task automatic step();
      logic acc, ev;
      logic [2*W-1:0] h;
      logic [W-1:0] lo, hi;
      @(posedge Clk);
      if (Rst) begin
         q.delete();
         bi = 0;
         movf = 1'b0;
         mclr = 1'b0;
      end else begin
         if (q.size() > 0 && ready) begin
            if (bi == 1) begin
               void'(q.pop_front());
               bi = 0;
            end else bi = 1;
         end
         acc = Capture && q.size() < 2;
         if (acc) q.push_back(sum);
         if (Capture && !acc) movf = 1'b1;
         mclr = acc;
      end
      @(negedge Clk);
      ev = q.size() > 0;
      h = ev ? q[0] : '0;
      lo = h[W-1:0];
      hi = h[2*W-1:W];
      chk("valid0", 64'(b0.m_valid), 64'(ev));
      chk("valid1", 64'(b1.m_valid), 64'(ev));
      chk("data0", 64'(b0.m_data), 64'(!ev ? '0 : bi == 1 ? hi : lo));
      chk("data1", 64'(b1.m_data), 64'(!ev ? '0 : bi == 1 ? lo : hi));
      chk("last0", 64'(b0.m_last), 64'(ev && bi == 1));
      chk("last1", 64'(b1.m_last), 64'(ev && bi == 1));
      chk("busy0", 64'(busy0), 64'(ev));
      chk("busy1", 64'(busy1), 64'(ev));
      chk("clr0", 64'(clr0), 64'(mclr));
      chk("clr1", 64'(clr1), 64'(mclr));
      chk("ovf0", 64'(ovf0), 64'(movf));
      chk("ovf1", 64'(ovf1), 64'(movf));
   endtask
   task automatic cap(input logic [63:0] v);
      sum = v;
      Capture = 1'b1;
      step();
      Capture = 1'b0;
   endtask
   initial begin
      step();
      step();
      chk("rst_valid", 64'(b0.m_valid), 64'd0);
      chk("rst_ovf", 64'(ovf0), 64'd0);
      Rst = 1'b0;
      // single result, ready high
      ready = 1'b1;
      cap(64'h0000_0005_0000_0003);
      chk("s1_clr", 64'(clr0), 64'd1);
      chk("s1_beat0_lo", 64'(b0.m_data), 64'h3);
      chk("s1_beat0_hi", 64'(b1.m_data), 64'h5);
      chk("s1_last0", 64'(b0.m_last), 64'd0);
      step();
      chk("s1_beat1_lo", 64'(b0.m_data), 64'h5);
      chk("s1_beat1_hi", 64'(b1.m_data), 64'h3);
      chk("s1_last1", 64'(b1.m_last), 64'd1);
      step();
      chk("s1_busy", 64'(busy0), 64'd0);
      // backpressure
      ready = 1'b0;
      cap(64'h0000_0005_0000_0003);
      repeat (3) begin
         step();
         chk("bp_hold", 64'(b0.m_data), 64'h3);
         chk("bp_valid", 64'(b0.m_valid), 64'd1);
      end
      ready = 1'b1;
      step();
      chk("bp_beat1", 64'(b0.m_data), 64'h5);
      step();
      // queued capture
      ready = 1'b0;
      cap(64'h1);
      chk("q_clr_a", 64'(clr0), 64'd1);
      cap(64'h2);
      chk("q_clr_b", 64'(clr0), 64'd1);
      chk("q_beat0", 64'(b0.m_data), 64'h1);
      ready = 1'b1;
      step();
      chk("q_beat1", 64'(b0.m_data), 64'h0);
      step();
      chk("q_beat2", 64'(b0.m_data), 64'h2);
      chk("q_nogap", 64'(b0.m_valid), 64'd1);
      step();
      chk("q_beat3", 64'(b0.m_data), 64'h0);
      step();
      chk("q_ovf", 64'(ovf0), 64'd0);
      // overflow
      ready = 1'b0;
      cap(64'h10);
      cap(64'h20);
      cap(64'h30);
      chk("ov_noclr", 64'(clr0), 64'd0);
      chk("ov_flag", 64'(ovf0), 64'd1);
      ready = 1'b1;
      repeat (5) step();
      // capture on the final-beat edge with pending full
      ready = 1'b0;
      cap(64'hA);
      cap(64'hB);
      ready = 1'b1;
      step();
      sum = 64'hC;
      Capture = 1'b1;
      step();
      Capture = 1'b0;
      chk("bd_clr", 64'(clr0), 64'd1);
      chk("bd_beat", 64'(b0.m_data), 64'hB);
      step();
      step();
      chk("bd_third", 64'(b0.m_data), 64'hC);
      chk("bd_nogap", 64'(b0.m_valid), 64'd1);
      repeat (2) step();
      // reset mid-transfer
      cap(64'h0000_0009_0000_0007);
      step();
      ready = 1'b0;
      Rst = 1'b1;
      step();
      chk("mr_valid", 64'(b0.m_valid), 64'd0);
      chk("mr_busy", 64'(busy0), 64'd0);
      chk("mr_ovf", 64'(ovf0), 64'd0);
      chk("mr_clr", 64'(clr0), 64'd0);
      Rst = 1'b0;
      ready = 1'b1;
      repeat (3) step();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ready = $urandom_range(9) < 7;
         Capture = $urandom_range(9) < 3;
         sum = {$urandom, $urandom};
         Rst = $urandom_range(299) == 0;
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
